// File: rtl/pc_fetch_pkg.sv
// Shared types and widths for the PC / fetch-control stage.
package pc_fetch_pkg;

    localparam int unsigned PC_W  = 12;
    localparam int unsigned CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/pc_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and enable.
module pc_cycle_counter
    import pc_fetch_pkg::*;
#(
    parameter int unsigned W = CYC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencing (IDLE/RUN/DONE) with relative branches.
// Define PC_FETCH_CYCLE_COUNT_EN to add the cycle_count output.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     D          = PC_W,
    parameter logic [D-1:0]    START_ADDR = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             branch_en,
    input  logic             branch_flag,
    input  logic [D-1:0]     target,
    input  logic             halt,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
`ifdef PC_FETCH_CYCLE_COUNT_EN
    output logic             done,
    output logic [CYC_W-1:0] cycle_count
`else
    output logic             done
`endif
);

    fetch_state_t state_q;

    // Bitwise AND keeps an unknown branch_flag from leaking when branch_en is low.
    logic taken;
    assign taken = branch_en & branch_flag;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            prog_ctr    <= START_ADDR;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= RUN;
                        prog_ctr    <= START_ADDR;
                        fetch_valid <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q     <= DONE;
                        fetch_valid <= 1'b0;
                        done        <= 1'b1;
                    end else if (taken) begin
                        prog_ctr <= prog_ctr + target;
                    end else begin
                        prog_ctr <= prog_ctr + D'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_FETCH_CYCLE_COUNT_EN
    logic launch;
    logic running;
    assign launch  = start && ((state_q == IDLE) || (state_q == DONE));
    assign running = (state_q == RUN);

    pc_cycle_counter #(
        .W (CYC_W)
    ) u_cycle_counter (
        .clk    (Clk),
        .reset  (Reset),
        .clear  (launch),
        .enable (running),
        .count  (cycle_count)
    );
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage that consumes the signed branch offset produced by the branch-target lookup table. It holds the architectural PC and sequences program start, run and halt. Each cycle it advances the PC by one, or by the lookup-table offset on a taken branch. It drives the instruction-memory address and a done flag to the test harness.

Parameters:
D, 12, PC and branch-target width in bits; all PC arithmetic is modulo 2^D.
START_ADDR, 0, PC value loaded on reset and on every program launch.

Ports:
Clk  input  1  system clock, rising-edge.
Reset  input  1  synchronous, active-high reset.
start  input  1  launch request, sampled in IDLE or DONE.
branch_en  input  1  decoded instruction is a conditional branch.
branch_flag  input  1  ALU condition flag; branch is taken when branch_en && branch_flag.
target  input  D  signed two's-complement PC offset from the branch-target lookup table.
halt  input  1  decoded instruction is a halt.
prog_ctr  output  D  registered instruction-memory address.
fetch_valid  output  1  high while in RUN; prog_ctr addresses a live instruction.
done  output  1  high while in DONE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high on Clk.
- Reset values: state=IDLE, prog_ctr=START_ADDR, fetch_valid=0, done=0. Reset overrides every other input in the same cycle, including mid-run.
- States: IDLE, RUN, DONE; encoded as a typedef enum.
- IDLE:
  - start=1 -> RUN; prog_ctr is set to START_ADDR.
  - Otherwise stay in IDLE, PC holds.
- RUN, priority order evaluated each cycle:
  - halt=1 -> DONE; prog_ctr holds (it keeps the halt instruction's address). Halt beats a simultaneous taken branch.
  - branch_en && branch_flag -> prog_ctr <= prog_ctr + target. Addition is D-bit and wraps mod 2^D, so negative targets move the PC backward.
  - Otherwise prog_ctr <= prog_ctr + 1; 2^D-1 wraps to 0.
  - start is ignored in RUN.
  - target is ignored unless the branch is taken.
- DONE:
  - done=1 and prog_ctr holds.
  - start=1 -> RUN with prog_ctr=START_ADDR; done drops on that same edge.
- Latency:
  - All outputs are registered.
  - A control input sampled at edge N is reflected in prog_ctr, fetch_valid and done after edge N.
  - The first fetch address after launch is START_ADDR, valid for one full cycle before the first increment.
- fetch_valid = (state==RUN); done = (state==DONE). Both derive from registered state, with no combinational path from inputs.
- Target value 0 on a taken branch holds the PC and forms a legal spin loop; no special handling.
- X on branch_flag when branch_en=0 must not propagate into prog_ctr.

Optional Feature:
Macro PC_FETCH_CYCLE_COUNT_EN.
- Defined:
  - Adds output cycle_count, 16 bits, reset to 0.
  - Cleared to 0 on each launch (start accepted in IDLE or DONE).
  - Increments by 1 every cycle in RUN, including the halt cycle.
  - Saturates at 16'hFFFF.
  - Holds in IDLE and DONE.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pc_fetch_pkg:
  - typedef enum fetch_state_t {IDLE, RUN, DONE};
  - localparam PC_W=12, matching the lookup-table target width;
  - localparam CYC_W=16.
- One natural sub-module: pc_cycle_counter, the saturating counter with clear and enable. It is instantiated only under PC_FETCH_CYCLE_COUNT_EN.
- Next-PC selection stays inline.

Test Plan:
- Reset and sequential run: Reset high 2 cycles -> prog_ctr=0, fetch_valid=0, done=0. Pulse start -> fetch_valid=1, prog_ctr sequence 0,1,2,3 on successive cycles.
- Forward branch: at prog_ctr=10, branch_en=1, branch_flag=1, target=22 -> next prog_ctr=32. Same with branch_flag=0 -> 11.
- Backward branch and wrap:
  - prog_ctr=40, target=-26 (12'hFE6), taken -> 14.
  - prog_ctr=5, target=-173, taken -> 12'hF58.
  - prog_ctr=12'hFFF, no branch -> 12'h000.
- Halt priority and relaunch:
  - prog_ctr=50, halt=1 with a taken branch (target=171) -> prog_ctr stays 50, done=1, fetch_valid=0 next cycle.
  - start in DONE -> prog_ctr=0, done=0, fetch_valid=1.
- Reset mid-run: at prog_ctr=100 in RUN, Reset=1 -> next cycle prog_ctr=0, state IDLE, fetch_valid=0. A start asserted together with Reset is ignored.
- Cycle count (macro defined):
  - Launch, run 7 cycles, halt on the 8th -> cycle_count=8, holding in DONE.
  - Relaunch -> cycle_count clears to 0.
  - Forced 16'hFFFF stays 16'hFFFF while running.
